// File: rtl/key_event_arbiter.sv
// key_event_arbiter: debounces KEYS active-low buttons, latches one pending
// press per key, and shares a single valid/ready event port among the keys
// through a round-robin arbiter.
//
// Optional feature: define KEY_EVENT_ARBITER_OVERFLOW_EN to add lost_cnt_o
// (saturating count of dropped presses) and lost_clr_i (clears that count).
//
// Handshake: evt_valid_o/evt_id_o are registered; an event transfers on a
// posedge where evt_valid_o and evt_ready_i are both 1. While valid is high,
// evt_id_o does not change until that transfer, and evt_ready_i has no
// effect while valid is low.
module key_event_arbiter #(
    parameter int KEYS           = 4,
    parameter int CLK_FREQ_MHZ   = 150,
    parameter int GLITCH_TIME_NS = 100
) (
    input  logic                      clk_i,
    input  logic                      srst_i,
    input  logic [KEYS-1:0]           key_i,
    output logic                      evt_valid_o,
    output logic [$clog2(KEYS)-1:0]   evt_id_o,
    input  logic                      evt_ready_i,
    output logic [KEYS-1:0]           pending_o
`ifdef KEY_EVENT_ARBITER_OVERFLOW_EN
    ,
    output logic [7:0]                lost_cnt_o,
    input  logic                      lost_clr_i
`endif
);

    localparam int GLITCH_CYCLES = CLK_FREQ_MHZ * GLITCH_TIME_NS / 1000;
    localparam int ID_W          = $clog2(KEYS);
    localparam int CNT_W         = (GLITCH_CYCLES < 1) ? 1 : $clog2(GLITCH_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(GLITCH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(GLITCH_CYCLES - 1);
    localparam logic [ID_W-1:0]  ID_LAST = ID_W'(KEYS - 1);

    if (GLITCH_CYCLES < 1) begin : g_glitch_check
        $error("key_event_arbiter: GLITCH_CYCLES must be at least 1");
    end

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } state_t;

    logic [KEYS-1:0]  sync1_q;
    logic [KEYS-1:0]  sync2_q;
    logic [CNT_W-1:0] cnt_q [KEYS];
    logic [KEYS-1:0]  det_q;
    logic [KEYS-1:0]  pending_q;
    logic [ID_W-1:0]  last_grant_q;
    state_t           state_q;

    logic             hs;
    logic [KEYS-1:0]  accept_mask;
    logic [KEYS-1:0]  pend_nxt;
    logic [KEYS-1:0]  cand;
    logic [ID_W:0]    idle_pick;
    logic [ID_W:0]    next_pick;

    // First set bit of req scanning upward from last+1, wrapping at KEYS.
    // Result is {found, id}.
    function automatic logic [ID_W:0] rr_pick(input logic [KEYS-1:0] req,
                                              input logic [ID_W-1:0] last);
        logic            found;
        logic [ID_W-1:0] id;
        int              idx;
        found = 1'b0;
        id    = '0;
        for (int off = 1; off <= KEYS; off++) begin
            idx = int'(last) + off;
            if (idx >= KEYS) begin
                idx = idx - KEYS;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                id    = ID_W'(idx);
            end
        end
        return {found, id};
    endfunction

    // Two-flop synchronizer; resets to released so a held key restarts debounce.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
        end
    end

    // Per-key integration counter; the detect pulse is registered on the
    // G-1 -> G step, so a long hold yields only one pulse.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            for (int k = 0; k < KEYS; k++) begin
                cnt_q[k] <= '0;
            end
            det_q <= '0;
        end else begin
            for (int k = 0; k < KEYS; k++) begin
                if (sync2_q[k]) begin
                    cnt_q[k] <= '0;
                end else if (cnt_q[k] != CNT_MAX) begin
                    cnt_q[k] <= cnt_q[k] + 1'b1;
                end
                det_q[k] <= !sync2_q[k] && (cnt_q[k] == CNT_PRE);
            end
        end
    end

    // Next pending set and arbitration candidates for this cycle.
    always_comb begin
        hs          = evt_valid_o && evt_ready_i;
        accept_mask = '0;
        if (hs) begin
            accept_mask[evt_id_o] = 1'b1;
        end
        // A same-cycle detect of the accepted key re-arms its bit.
        pend_nxt  = (pending_q & ~accept_mask) | det_q;
        // The accepted key is not re-offered back to back, even if re-armed.
        cand      = pend_nxt & ~accept_mask;
        idle_pick = rr_pick(pending_q, last_grant_q);
        next_pick = rr_pick(cand, evt_id_o);
    end

    // Arbiter FSM with registered valid/id, plus the pending bit register.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q      <= S_IDLE;
            evt_valid_o  <= 1'b0;
            evt_id_o     <= '0;
            last_grant_q <= ID_LAST;
            pending_q    <= '0;
        end else begin
            pending_q <= pend_nxt;
            case (state_q)
                S_IDLE: begin
                    if (idle_pick[ID_W]) begin
                        state_q     <= S_OFFER;
                        evt_valid_o <= 1'b1;
                        evt_id_o    <= idle_pick[ID_W-1:0];
                    end
                end
                S_OFFER: begin
                    if (hs) begin
                        last_grant_q <= evt_id_o;
                        if (next_pick[ID_W]) begin
                            evt_id_o <= next_pick[ID_W-1:0];
                        end else begin
                            state_q     <= S_IDLE;
                            evt_valid_o <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    evt_valid_o <= 1'b0;
                end
            endcase
        end
    end

    assign pending_o = pending_q;

`ifdef KEY_EVENT_ARBITER_OVERFLOW_EN
    localparam int DC_W = $clog2(KEYS + 1);

    logic [KEYS-1:0] drop;
    logic [DC_W-1:0] drop_cnt;
    logic [8:0]      lost_sum;

    // Count detects that hit a still-pending, not-accepted key.
    always_comb begin
        drop     = det_q & pending_q & ~accept_mask;
        drop_cnt = '0;
        for (int k = 0; k < KEYS; k++) begin
            drop_cnt = drop_cnt + DC_W'(drop[k]);
        end
        lost_sum = {1'b0, lost_cnt_o} + 9'(drop_cnt);
    end

    // Saturating lost-event counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk_i) begin
        if (srst_i || lost_clr_i) begin
            lost_cnt_o <= '0;
        end else if (lost_sum > 9'd255) begin
            lost_cnt_o <= 8'd255;
        end else begin
            lost_cnt_o <= lost_sum[7:0];
        end
    end
`endif

endmodule

// File: doc/key_event_arbiter.md
Name: key_event_arbiter

Overview:
- Debounces KEYS independent active-low buttons with per-key integration counters.
- Queues one pending press event per key and shares a single event output among all keys through a round-robin arbiter with a valid/ready handshake.
- Sits between the raw board buttons and the control logic that consumes key events; replaces per-key debouncer instances plus ad-hoc OR-ing of strobes.

Parameters:
- KEYS, 4, number of key inputs (2..16).
- CLK_FREQ_MHZ, 150, clock frequency in MHz.
- GLITCH_TIME_NS, 100, minimum stable-low time for a valid press.
- GLITCH_CYCLES (localparam), CLK_FREQ_MHZ*GLITCH_TIME_NS/1000, debounce length in clocks; must be >= 1 (elaboration error otherwise).
- ID_W (localparam), $clog2(KEYS), event id width.

Ports:
- clk_i  in  1  single clock for all logic.
- srst_i  in  1  synchronous reset, active-high.
- key_i  in  KEYS  raw asynchronous buttons, 0 = pressed.
- evt_valid_o  out  1  event available.
- evt_id_o  out  ID_W  index of the pressed key; valid only while evt_valid_o = 1.
- evt_ready_i  in  1  consumer accepts the event; a handshake occurs when evt_valid_o and evt_ready_i are both 1 at a posedge.
- pending_o  out  KEYS  per-key pending-event bits (status).

Behaviour:
- Sync: each key_i bit passes through a 2-FF synchronizer; the synchronizer resets to 1 (released).
- Debounce counter, per key, width $clog2(GLITCH_CYCLES+1):
  - Clears to 0 on any cycle where the synced key is 1.
  - Increments while the synced key is 0, saturating at GLITCH_CYCLES.
  - A press is detected on the single cycle the counter transitions GLITCH_CYCLES-1 -> GLITCH_CYCLES.
  - Holding the key produces exactly one detect; release followed by a new stable low is required for the next detect.
- Latency: key_i sampled low at edge 0 and held -> pending bit set at edge GLITCH_CYCLES+2 -> evt_valid_o = 1 at edge GLITCH_CYCLES+3, provided the arbiter is idle.
- Glitch filtering:
  - Low for GLITCH_CYCLES-1 consecutive samples or fewer -> no event.
  - Low for exactly GLITCH_CYCLES samples -> one event.
- Pending bit, per key:
  - Set on detect; cleared on handshake of that key.
  - Detect in the same cycle as that key's handshake -> bit stays 1 (new event).
  - Detect while the bit is already 1 and not being accepted -> event dropped.
- Arbiter, 2 states:
  - IDLE: evt_valid_o = 0. If any pending bit is 1, grant the first pending key scanning from last_grant+1 modulo KEYS, load evt_id_o, go to OFFER.
  - OFFER: evt_valid_o = 1. evt_id_o is held stable until handshake.
  - OFFER on handshake: update last_grant := evt_id_o and clear that pending bit. If other pending bits (excluding the accepted key, after applying same-cycle detects) are nonzero, grant the next one round-robin and stay in OFFER, giving back-to-back events with no bubble. Otherwise go to IDLE.
  - Starvation bound: a pending key waits at most KEYS-1 handshakes.
- Reset values:
  - evt_valid_o = 0, evt_id_o = 0, pending_o = 0.
  - Counters 0, last_grant = KEYS-1, so key 0 has first priority.
  - State IDLE.
- Reset mid-operation: any offered or pending event is discarded. A key held low across reset is re-debounced from scratch and yields exactly one event GLITCH_CYCLES+3 edges after the first post-reset edge.
- evt_ready_i while evt_valid_o = 0 is ignored.

Optional Feature:
- Macro: KEY_EVENT_ARBITER_OVERFLOW_EN.
- Defined:
  - Adds output lost_cnt_o [7:0], reset 0.
  - lost_cnt_o increments by 1 for each dropped detect, counting multiple keys dropping in the same cycle individually, and saturates at 255.
  - Adds input lost_clr_i; lost_clr_i = 1 clears the count, and clear takes priority over a same-cycle increment.
- Undefined: neither port exists and drops are silent; all other behaviour is identical.

Test Plan (KEYS=4, CLK_FREQ_MHZ=150, GLITCH_TIME_NS=100 -> GLITCH_CYCLES=15):
- Clean press: key_i[2]=0 for 20 cycles, evt_ready_i=1 -> evt_valid_o rises at edge 18 with evt_id_o=2, high for exactly 1 cycle, then pending_o=0.
- Glitch filtering: key_i[1] low for 14 cycles, then 3 bursts of 3 low / 3 high -> no evt_valid_o, pending_o stays 0. Then low 15 cycles -> exactly one event, id 1.
- Long press: key_i[0] held low 60 cycles, ready=1 -> exactly one handshake, id 0.
- Round-robin with backpressure:
  - Keys 0, 1, 3 pressed simultaneously, evt_ready_i=0 for 10 cycles after valid -> evt_id_o stays 0 throughout.
  - Then ready=1 -> ids 0, 1, 3 on consecutive cycles with no gap.
  - Repeat with last_grant=1 -> order 3, 0, 1.
- Drop/overflow: ready=0, key 2 pressed, released, pressed again (each 15+ cycles) -> pending_o[2]=1 and a single event once ready=1. With the macro defined, lost_cnt_o=1; a lost_clr_i pulse returns it to 0.
- Reset mid-operation: srst_i=1 for 1 cycle while OFFER with id 3 and key 3 still held -> evt_valid_o=0 next cycle, then one new event id 3 at edge 18 after reset release.
